accum_readout: RTL and testbench

ACCUM_READOUT -- requirements
Module: accum_readout

---
 rtl/rbm_pkg.sv | 18 +
 rtl/rbm_fifo2.sv | 36 +++
 rtl/accum_readout.sv | 84 ++++++++
 tb/tb_accum_readout.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbm_pkg.sv
// rbm_pkg: shared tile geometry, fixed-point types and the weight-update rounding used by accum_readout.
package rbm_pkg;
  localparam int I_TILE = 64;
  localparam int H_TILE = 64;
  localparam int ADDR_W = $clog2(I_TILE * H_TILE);
  localparam int ACC_FRAC = 23;
  localparam int DW_FRAC = 12;
  typedef logic signed [31:0] acc_t;
  typedef logic signed [15:0] dw_t;
  // (pos - neg) >>> (ACC_FRAC - DW_FRAC + lr_shift), rounded half up, saturated to dw_t
  function automatic dw_t round_sat(input acc_t pos, input acc_t neg, input logic [3:0] lr_shift);
    logic signed [33:0] r;
    int s;
    s = ACC_FRAC - DW_FRAC + int'(lr_shift);
    r = (34'(pos) - 34'(neg) + (34'sd1 <<< (s - 1))) >>> s;
    return r > 34'sd32767 ? 16'sh7fff : r < -34'sd32768 ? 16'sh8000 : dw_t'(r[15:0]);
  endfunction
endpackage

// File: rtl/rbm_fifo2.sv
// rbm_fifo2: 2-entry valid/ready FIFO; exposes occupancy so the producer can run credit-based.
module rbm_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign out_data = mem[rp];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) mem[wp] <= in_data;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/accum_readout.sv
// accum_readout: streams pos/neg accumulator banks out as rounded, saturated weight deltas,
// optionally clearing each bank entry as it is consumed.
module accum_readout #(
  parameter int I_TILE = rbm_pkg::I_TILE,
  parameter int H_TILE = rbm_pkg::H_TILE,
  parameter int ADDR_W = $clog2(I_TILE * H_TILE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               lr_shift,
  input  logic                     clr_en,
  output logic                     bank_rd_en,
  output logic [ADDR_W-1:0]        bank_rd_addr,
  input  logic signed [31:0]       pos_rd_data,
  input  logic signed [31:0]       neg_rd_data,
  output logic                     bank_wr_en,
  output logic [ADDR_W-1:0]        bank_wr_addr,
  output logic                     dw_valid,
  input  logic                     dw_ready,
  output logic signed [15:0]       dw_data,
  output logic [ADDR_W-1:0]        dw_addr,
  output logic                     dw_last,
  output logic                     busy,
  output logic                     done
);
  import rbm_pkg::*;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(I_TILE * H_TILE - 1);
  localparam int FW = 1 + ADDR_W + 16;
  logic [1:0] state, occ;
  logic [3:0] lr_q;
  logic clr_q, cap, pop, drained, f_in_ready;
  logic [ADDR_W-1:0] rd_addr, cap_addr;
  logic [FW-1:0] f_in, f_out;
  dw_t res;
  assign pop = dw_valid && dw_ready;
  // occupancy counted after this cycle's pop, so one beat per cycle is sustainable
  assign bank_rd_en = state == RUN && f_in_ready && (occ - {1'b0, pop} + {1'b0, cap}) < 2'd2;
  assign bank_rd_addr = rd_addr;
  assign bank_wr_en = cap && clr_q;
  assign bank_wr_addr = cap_addr;
  assign res = round_sat(pos_rd_data, neg_rd_data, lr_q);
  assign f_in = {cap_addr == LAST, cap_addr, res};
  assign {dw_last, dw_addr, dw_data} = f_out;
  assign drained = !cap && occ == {1'b0, pop};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lr_q <= 4'd0;
      clr_q <= 1'b0;
      rd_addr <= '0;
      cap <= 1'b0;
      cap_addr <= '0;
    end else begin
      cap <= bank_rd_en;
      cap_addr <= rd_addr;
      state <= (state == IDLE && start) ? RUN :
               (state == RUN && bank_rd_en && rd_addr == LAST) ? DRAIN :
               (state == DRAIN && drained) ? DONE :
               (state == DONE) ? IDLE : state;
      if (state == IDLE && start) begin
        lr_q <= lr_shift;
        clr_q <= clr_en;
        rd_addr <= '0;
      end else if (bank_rd_en) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end
  rbm_fifo2 #(.W(FW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(cap),
    .in_ready(f_in_ready),
    .in_data(f_in),
    .out_valid(dw_valid),
    .out_ready(dw_ready),
    .out_data(f_out),
    .count(occ)
  );
endmodule

// File: tb/tb_accum_readout.sv
// tb_accum_readout: randomized passes of accum_readout checked against an arithmetic reference model.
module tb_accum_readout;
  localparam int N = 4096;
  localparam int AW = 12;
  logic clk = 0, rst_n = 0, start = 0, clr_en = 0, dw_ready = 0, load = 0;
  logic [3:0] lr_shift = 0;
  logic bank_rd_en, bank_wr_en, dw_valid, dw_last, busy, done;
  logic [AW-1:0] bank_rd_addr, bank_wr_addr, dw_addr;
  logic signed [31:0] pos_rd_data, neg_rd_data;
  logic signed [15:0] dw_data;
  logic signed [31:0] pos_mem [N], neg_mem [N], pos_ref [N], neg_ref [N];
  logic signed [15:0] got [N];
  logic [AW+16:0] held_val;
  int ncmp = 0, nerr = 0, beat = 0, rd_exp = 0, wr_cnt = 0, n_done = 0, stall = 0, cur_lr = 0;
  bit stall_armed = 0, rnd_ready = 0, held = 0, last_hs = 0, prev_done = 0;

  always #5 clk = ~clk;

  accum_readout dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lr_shift(lr_shift), .clr_en(clr_en),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
    .pos_rd_data(pos_rd_data), .neg_rd_data(neg_rd_data),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr),
    .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_data(dw_data), .dw_addr(dw_addr),
    .dw_last(dw_last), .busy(busy), .done(done)
  );

  // bank pair: 1-cycle read latency, clear writes, bulk load from the reference arrays
  always @(posedge clk) begin
    if (bank_rd_en) begin
      pos_rd_data <= pos_mem[bank_rd_addr];
      neg_rd_data <= neg_mem[bank_rd_addr];
    end
    if (bank_wr_en) begin
      pos_mem[bank_wr_addr] <= '0;
      neg_mem[bank_wr_addr] <= '0;
      wr_cnt <= wr_cnt + 1;
    end
    if (load) for (int i = 0; i < N; i++) begin
      pos_mem[i] <= pos_ref[i];
      neg_mem[i] <= neg_ref[i];
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] got_v, input logic signed [63:0] exp_v);
    ncmp++;
    if (got_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  function automatic longint ref_dw(longint p, longint n, int lr);
    longint den, num, q;
    den = longint'(1) << (11 + lr);
    num = p - n + den / 2;
    q = num / den;
    if (num < 0 && q * den != num) q--;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // ready driver and output monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_armed && dw_valid && dw_addr == 100) begin
        stall = 10;
        stall_armed = 0;
      end
      if (stall > 0) begin
        dw_ready = 0;
        stall--;
      end else dw_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (rst_n) begin
        if (prev_done) chk("done_pulse", done, 0);
        prev_done = done;
        if (done) n_done++;
        if (last_hs) begin
          chk("done_after_last", done, 1);
          last_hs = 0;
        end
        if (bank_rd_en) begin
          chk("rd_addr", bank_rd_addr, rd_exp);
          rd_exp++;
        end
        if (held) begin
          chk("hold_valid", dw_valid, 1);
          chk("hold_beat", {dw_last, dw_addr, dw_data}, held_val);
        end
        if (dw_valid && dw_ready) begin
          chk("dw_addr", dw_addr, beat);
          chk("dw_last", dw_last, beat == N - 1);
          if (beat < N) begin
            chk("dw_data", dw_data, ref_dw(pos_ref[beat], neg_ref[beat], cur_lr));
            got[beat] = dw_data;
          end
          if (beat == N - 1) begin
            chk("done_early", done, 0);
            last_hs = 1;
          end
          beat++;
        end
        held = dw_valid && !dw_ready;
        held_val = {dw_last, dw_addr, dw_data};
      end
    end
  end

  task automatic load_bank();
    @(negedge clk);
    load = 1;
    @(negedge clk);
    load = 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      pos_ref[i] = $urandom;
      neg_ref[i] = $urandom;
    end
  endtask

  task automatic arm(input int lr, input bit rr, input bit stl);
    beat = 0;
    rd_exp = 0;
    held = 0;
    last_hs = 0;
    cur_lr = lr;
    rnd_ready = rr;
    stall_armed = stl;
    stall = 0;
  endtask

  task automatic run_pass(input int lr, input bit clr, input bit rr, input bit stl, input bit poke, output int cyc);
    int d0;
    arm(lr, rr, stl);
    d0 = n_done;
    @(negedge clk);
    lr_shift = 4'(lr);
    clr_en = clr;
    start = 1;
    @(negedge clk);
    start = 0;
    lr_shift = 4'(lr + 5);
    clr_en = !clr;
    cyc = 1;
    while (n_done == d0 && cyc < 30000) begin
      start = poke && cyc == 500;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    repeat (3) @(negedge clk);
    chk("beats", beat, N);
    chk("pass_count", n_done - d0, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic bank_diffs(input bit vs_zero, output int diffs);
    diffs = 0;
    for (int i = 0; i < N; i++)
      if (vs_zero ? (pos_mem[i] != 0 || neg_mem[i] != 0) : (pos_mem[i] != pos_ref[i] || neg_mem[i] != neg_ref[i])) diffs++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, w0, diffs;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", bank_rd_en, 0);
    chk("rst_wr_en", bank_wr_en, 0);
    chk("rst_valid", dw_valid, 0);
    chk("rst_last", dw_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addrs", {bank_rd_addr, bank_wr_addr, dw_addr}, 0);
    chk("rst_data", dw_data, 0);

    // pass A: directed rounding/saturation corners, random ready, stall at 100, no clear
    fill_rand();
    pos_ref[0] = 32'h0080_0000; neg_ref[0] = 0;
    pos_ref[1] = 32'h7FFF_FFFF; neg_ref[1] = 32'h8000_0000;
    pos_ref[2] = 32'h8000_0000; neg_ref[2] = 32'h7FFF_FFFF;
    pos_ref[3] = 32'h0000_0400; neg_ref[3] = 0;
    pos_ref[4] = 0;             neg_ref[4] = 32'h0000_0400;
    load_bank();
    rst_n = 1;
    @(negedge clk);
    w0 = wr_cnt;
    run_pass(0, 0, 1, 1, 0, cyc);
    chk("one_lr0", got[0], 16'sh1000);
    chk("sat_pos", got[1], 32767);
    chk("sat_neg", got[2], -32768);
    chk("half_up_pos", got[3], 1);
    chk("half_up_neg", got[4], 0);
    chk("no_clr_writes", wr_cnt - w0, 0);
    bank_diffs(0, diffs);
    chk("bank_unchanged", diffs, 0);

    // pass B: lr_shift 2 with clear, start poked mid-pass
    fill_rand();
    pos_ref[0] = 32'h0080_0000; neg_ref[0] = 0;
    load_bank();
    w0 = wr_cnt;
    run_pass(2, 1, 1, 0, 1, cyc);
    chk("one_lr2", got[0], 16'sh0400);
    chk("clr_writes", wr_cnt - w0, N);
    bank_diffs(1, diffs);
    chk("bank_cleared", diffs, 0);

    // pass C: continuous ready sustains one beat per cycle
    fill_rand();
    load_bank();
    run_pass($urandom_range(0, 15), 0, 0, 0, 0, cyc);
    chk("throughput", cyc <= N + 8, 1);

    // pass D: reset at read address 100 aborts, then a clean restart
    fill_rand();
    load_bank();
    arm(3, 1, 0);
    @(negedge clk);
    lr_shift = 4'd3;
    clr_en = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!(bank_rd_en && bank_rd_addr == 100) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", bank_rd_en && bank_rd_addr == 100, 1);
    rst_n = 0;
    w0 = wr_cnt;
    @(negedge clk);
    chk("abort_ctl", {bank_rd_en, bank_wr_en, dw_valid, dw_last, busy, done}, 0);
    chk("abort_addrs", {bank_rd_addr, bank_wr_addr, dw_addr}, 0);
    chk("abort_data", dw_data, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_wr", wr_cnt - w0, 0);
    rst_n = 1;
    prev_done = 0;
    for (int i = 0; i < N; i++) begin
      pos_ref[i] = pos_mem[i];
      neg_ref[i] = neg_mem[i];
    end
    w0 = wr_cnt;
    run_pass($urandom_range(0, 15), 0, 1, 0, 0, cyc);
    chk("restart_no_wr", wr_cnt - w0, 0);
    bank_diffs(0, diffs);
    chk("restart_bank", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
